noc_config_sequencer: RTL and testbench
=======================================

# noc_config_sequencer

Programmable configure-word sequencer for the processor-configuration inputs of the NoC mesh. It replaces hand-timed per-processor `pX_configure` stimulus with a small program table. Each entry drives one configure word to one processor for a programmed number of cycles, then optionally waits for that processor's ready bit. It is parametrised in processor count, configure width and table depth, and sits between host or test control and the mesh's configure inputs.

## Interface
Parameters:
- `NUM_PROC`, 4: processors driven; must be ≥2.
- `CFG_W`, 11: configure word width.
- `DEPTH`, 8: program table entries; power of two.
- `HOLD_W`, 8: width of the per-entry hold count.
- `TMO_W`, 12: width of the ready-timeout counter.

Ports (`AW = $clog2(DEPTH)`, `PW = $clog2(NUM_PROC)`):
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `prog_we`  in  1  table write strobe.
- `prog_addr`  in  AW  table write address.
- `prog_dest`  in  PW  entry: target processor index.
- `prog_cfg`  in  CFG_W  entry: configure word.
- `prog_hold`  in  HOLD_W  entry: drive cycles; 0 is treated as 1.
- `prog_wait`  in  1  entry: wait for the target's ready bit after drive.
- `prog_len`  in  AW+1  number of entries to run, 0..DEPTH.
- `start`  in  1  run request, single-cycle pulse.
- `processor_ready_signals`  in  NUM_PROC  ready bits from the mesh.
- `p_configure`  out  NUM_PROC*CFG_W  processor i occupies slice `[i*CFG_W +: CFG_W]`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of run.
- `issued`  out  AW+1  entries completed in the current or last run.
- `timeout_err`  out  1  sticky; cleared by `start`.

## Operation
- The table is a register array with no reset; contents survive `reset`.
- A write with `prog_we` high while in IDLE stores the four fields at `prog_addr` on the clock edge. Writes while `busy` is high are ignored.
- State machine states: IDLE, DRIVE, GAP, WAIT, DONE.
- IDLE:
  - `start` with `prog_len`≠0: latch `prog_len`, load entry 0, set the hold counter, clear `issued` and `timeout_err`, go to DRIVE.
  - `start` with `prog_len`=0: go straight to DONE.
  - `prog_len` > DEPTH is clamped to DEPTH.
- DRIVE:
  - The target slice of `p_configure` = `cfg`; all other slices are 0.
  - Stay for max(hold,1) cycles, then go to GAP.
- GAP:
  - Exactly one cycle with `p_configure` all zero.
  - Then: if `wait` is set, go to WAIT; otherwise the entry completes.
- WAIT:
  - `p_configure` is 0.
  - The entry completes in the first cycle where `processor_ready_signals[dest]` is 1.
- Entry completion:
  - `issued` increments.
  - If `issued`+1 equals the latched length, go to DONE; otherwise load the next entry and go to DRIVE.
- DONE: `done`=1 for one cycle, then IDLE.
- Entries with `dest` ≥ NUM_PROC: nothing is driven during DRIVE; otherwise the timing is the same.
- `start` while `busy` is high is ignored.
- Asserting `reset` mid-run aborts immediately to IDLE.

## Timing
- Reset values: state IDLE, `p_configure`=0, `busy`=0, `done`=0, `issued`=0, `timeout_err`=0, all internal counters 0.
- All outputs are registered. No combinational path from any input to any output.
- With `start` sampled at edge 0, the first configure word is visible after edge 0. It is held for exactly max(hold,1) cycles.
- Entry cost without wait: hold+1 cycles. Back-to-back entries always have one zero cycle between them, even when the same processor is targeted twice in a row.
- Entry cost with wait: hold+1+k cycles. k ≥ 1 is the number of WAIT cycles up to and including the cycle in which ready is sampled high. Ready already high on entering WAIT gives k=1.
- `done` rises the cycle after the last entry completes. `busy` falls one cycle after that.

## Configuration
- `NOC_CFG_TIMEOUT_EN` defined:
  - WAIT counts cycles in a TMO_W counter.
  - If the counter reaches 2^TMO_W−1 without ready, set `timeout_err`, count the entry as completed, and continue the run.
- Not defined:
  - WAIT holds indefinitely until ready or `reset`.
  - `timeout_err` is tied to 0 and the timeout counter is not implemented.

## Test plan
- Reset, write entry 0 {dest 0, cfg 11'h205, hold 3, wait 0}, `prog_len`=1, pulse `start`:
  - slice 0 = 11'h205 for 3 cycles, then 0 for 1 cycle;
  - `done` pulse follows; `issued`=1.
- Entries {1, 11'h201, 2, 0} and {3, 11'h201, 2, 0}:
  - slice 1 = 11'h201 for 2 cycles, 1 zero cycle, then slice 3 = 11'h201 for 2 cycles;
  - total run 6 cycles before `done`.
- Entry with wait=1, dest 2; raise `processor_ready_signals[2]` 5 cycles after GAP:
  - `busy` stays high until then;
  - `issued` increments on the ready cycle;
  - `done` comes one cycle later.
- With `NOC_CFG_TIMEOUT_EN`, TMO_W=4, ready held low: `timeout_err`=1 after 15 WAIT cycles and the run completes. Without the macro, the bench sees no `done` after 100 cycles.
- Assert `reset` during DRIVE: `p_configure`=0 and `busy`=0 asynchronously. Re-run with `start` and the table contents are unchanged.
- Edge cases:
  - `prog_len`=0 gives `done` with `issued`=0 and no drive;
  - `start` while busy has no effect;
  - hold=0 drives 1 cycle.

Source files
------------

// File: rtl/noc_config_sequencer.sv
// rtl/noc_config_sequencer.sv - program-table driven configure-word sequencer for the NoC mesh
// Optional ready-timeout support is enabled by defining NOC_CFG_TIMEOUT_EN.
module noc_config_sequencer #(
   parameter int NUM_PROC = 4,
   parameter int CFG_W    = 11,
   parameter int DEPTH    = 8,
   parameter int HOLD_W   = 8,
   parameter int TMO_W    = 12
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                prog_we,
   input  logic [$clog2(DEPTH)-1:0]            prog_addr,
   input  logic [$clog2(NUM_PROC)-1:0]         prog_dest,
   input  logic [CFG_W-1:0]                    prog_cfg,
   input  logic [HOLD_W-1:0]                   prog_hold,
   input  logic                                prog_wait,
   input  logic [$clog2(DEPTH):0]              prog_len,
   input  logic                                start,
   input  logic [NUM_PROC-1:0]                 processor_ready_signals,
   output logic [NUM_PROC*CFG_W-1:0]           p_configure,
   output logic                                busy,
   output logic                                done,
   output logic [$clog2(DEPTH):0]              issued,
   output logic                                timeout_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = $clog2(NUM_PROC);
   localparam logic [AW:0]       DEPTH_L  = (AW+1)'(DEPTH);
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_GAP,
      ST_WAIT,
      ST_DONE
   } state_t;

   // Program table: plain registers, deliberately not reset so a run can be repeated after reset.
   logic [PW-1:0]     tbl_dest_q [DEPTH];
   logic [CFG_W-1:0]  tbl_cfg_q  [DEPTH];
   logic [HOLD_W-1:0] tbl_hold_q [DEPTH];
   logic              tbl_wait_q [DEPTH];

   state_t                    state_q, state_d;
   logic [NUM_PROC*CFG_W-1:0] pcfg_q, pcfg_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic [AW:0]               issued_q, issued_d;
   logic [AW:0]               len_q, len_d;
   logic [HOLD_W-1:0]         hold_q, hold_d;
   logic [PW-1:0]             dest_q, dest_d;
   logic                      wait_q, wait_d;

   logic                      load;
   logic                      complete;
   logic [AW-1:0]             ld_idx;
   logic [PW-1:0]             ld_dest;
   logic [CFG_W-1:0]          ld_cfg;
   logic [HOLD_W-1:0]         ld_hold;
   logic                      ld_wait;
   logic [(1<<PW)-1:0]        ready_ext;

`ifdef NOC_CFG_TIMEOUT_EN
   logic [TMO_W-1:0]          tmo_q, tmo_d, tmo_inc;
   logic                      tmo_err_q, tmo_err_d;
`endif

   always_ff @(posedge clock) begin
      if (prog_we && state_q == ST_IDLE) begin
         tbl_dest_q[prog_addr] <= prog_dest;
         tbl_cfg_q[prog_addr]  <= prog_cfg;
         tbl_hold_q[prog_addr] <= prog_hold;
         tbl_wait_q[prog_addr] <= prog_wait;
      end
   end

   assign ld_dest = tbl_dest_q[ld_idx];
   assign ld_cfg  = tbl_cfg_q[ld_idx];
   assign ld_hold = tbl_hold_q[ld_idx];
   assign ld_wait = tbl_wait_q[ld_idx];

   // Padding the ready vector to 2**PW entries makes out-of-range destinations read as not ready.
   always_comb begin
      ready_ext = '0;
      ready_ext[NUM_PROC-1:0] = processor_ready_signals;
   end

   always_comb begin
      state_d  = state_q;
      pcfg_d   = '0;
      issued_d = issued_q;
      len_d    = len_q;
      hold_d   = hold_q;
      dest_d   = dest_q;
      wait_d   = wait_q;
      load     = 1'b0;
      complete = 1'b0;
      ld_idx   = '0;
`ifdef NOC_CFG_TIMEOUT_EN
      tmo_d     = tmo_q;
      tmo_err_d = tmo_err_q;
      tmo_inc   = tmo_q + TMO_W'(1);
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               issued_d = '0;
`ifdef NOC_CFG_TIMEOUT_EN
               tmo_err_d = 1'b0;
`endif
               if (prog_len == '0) begin
                  state_d = ST_DONE;
               end else begin
                  len_d = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
                  load  = 1'b1;
               end
            end
         end
         ST_DRIVE: begin
            if (hold_q <= HOLD_ONE) begin
               state_d = ST_GAP;
            end else begin
               hold_d = hold_q - HOLD_ONE;
               pcfg_d = pcfg_q;
            end
         end
         ST_GAP: begin
            if (wait_q) begin
               state_d = ST_WAIT;
`ifdef NOC_CFG_TIMEOUT_EN
               tmo_d = '0;
`endif
            end else begin
               complete = 1'b1;
            end
         end
         ST_WAIT: begin
            if (ready_ext[dest_q]) begin
               complete = 1'b1;
            end
`ifdef NOC_CFG_TIMEOUT_EN
            else if (&tmo_inc) begin
               tmo_err_d = 1'b1;
               complete  = 1'b1;
            end else begin
               tmo_d = tmo_inc;
            end
`endif
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (complete) begin
         issued_d = issued_q + 1'b1;
         if (issued_d == len_q) begin
            state_d = ST_DONE;
         end else begin
            load   = 1'b1;
            ld_idx = issued_d[AW-1:0];
         end
      end

      // Entry load: the configure word goes straight into the output register for the next cycle.
      if (load) begin
         state_d = ST_DRIVE;
         dest_d  = ld_dest;
         wait_d  = ld_wait;
         hold_d  = (ld_hold == '0) ? HOLD_ONE : ld_hold;
         for (int i = 0; i < NUM_PROC; i++) begin
            if (int'(ld_dest) == i) begin
               pcfg_d[i*CFG_W +: CFG_W] = ld_cfg;
            end
         end
      end

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         pcfg_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         issued_q <= '0;
         len_q    <= '0;
         hold_q   <= '0;
         dest_q   <= '0;
         wait_q   <= 1'b0;
`ifdef NOC_CFG_TIMEOUT_EN
         tmo_q     <= '0;
         tmo_err_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         pcfg_q   <= pcfg_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         issued_q <= issued_d;
         len_q    <= len_d;
         hold_q   <= hold_d;
         dest_q   <= dest_d;
         wait_q   <= wait_d;
`ifdef NOC_CFG_TIMEOUT_EN
         tmo_q     <= tmo_d;
         tmo_err_q <= tmo_err_d;
`endif
      end
   end

   assign p_configure = pcfg_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign issued      = issued_q;
`ifdef NOC_CFG_TIMEOUT_EN
   assign timeout_err = tmo_err_q;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_config_sequencer.sv
// tb/tb_noc_config_sequencer.sv - directed self-checking bench for noc_config_sequencer
// Exercises the NOC_CFG_TIMEOUT_EN path when that macro is defined.
module tb_noc_config_sequencer;

   localparam int NUM_PROC = 4;
   localparam int CFG_W    = 11;
   localparam int DEPTH    = 8;
   localparam int HOLD_W   = 8;
`ifdef NOC_CFG_TIMEOUT_EN
   localparam int TMO_W    = 4;
`else
   localparam int TMO_W    = 12;
`endif
   localparam int AW = 3;
   localparam int PW = 2;
   localparam int VW = NUM_PROC*CFG_W;

   logic              clock = 1'b0;
   logic              reset;
   logic              prog_we;
   logic [AW-1:0]     prog_addr;
   logic [PW-1:0]     prog_dest;
   logic [CFG_W-1:0]  prog_cfg;
   logic [HOLD_W-1:0] prog_hold;
   logic              prog_wait;
   logic [AW:0]       prog_len;
   logic              start;
   logic [NUM_PROC-1:0] processor_ready_signals;
   logic [VW-1:0]     p_configure;
   logic              busy;
   logic              done;
   logic [AW:0]       issued;
   logic              timeout_err;

   int total = 0;
   int bad   = 0;

   noc_config_sequencer #(
      .NUM_PROC(NUM_PROC), .CFG_W(CFG_W), .DEPTH(DEPTH), .HOLD_W(HOLD_W), .TMO_W(TMO_W)
   ) dut (
      .clock(clock),
      .reset(reset),
      .prog_we(prog_we),
      .prog_addr(prog_addr),
      .prog_dest(prog_dest),
      .prog_cfg(prog_cfg),
      .prog_hold(prog_hold),
      .prog_wait(prog_wait),
      .prog_len(prog_len),
      .start(start),
      .processor_ready_signals(processor_ready_signals),
      .p_configure(p_configure),
      .busy(busy),
      .done(done),
      .issued(issued),
      .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input int addr, input int dest, input logic [CFG_W-1:0] cfg,
                     input int hold, input logic wt);
      prog_we   = 1'b1;
      prog_addr = AW'(addr);
      prog_dest = PW'(dest);
      prog_cfg  = cfg;
      prog_hold = HOLD_W'(hold);
      prog_wait = wt;
      tick();
      prog_we   = 1'b0;
   endtask

   task automatic go(input int len);
      prog_len = (AW+1)'(len);
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   function automatic logic [VW-1:0] sl(input int p, input logic [CFG_W-1:0] c);
      logic [VW-1:0] v;
      v = '0;
      v[p*CFG_W +: CFG_W] = c;
      return v;
   endfunction

   initial begin
      int n;
      reset = 1'b1;
      prog_we = 1'b0; prog_addr = '0; prog_dest = '0; prog_cfg = '0;
      prog_hold = '0; prog_wait = 1'b0; prog_len = '0; start = 1'b0;
      processor_ready_signals = '0;
      #12;
      chk("rst_pcfg", 64'(p_configure), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_issued", 64'(issued), 64'd0);
      chk("rst_tmo", 64'(timeout_err), 64'd0);
      reset = 1'b0;
      tick();

      // single entry, hold 3
      wr(0, 0, 11'h205, 3, 1'b0);
      go(1);
      chk("t1_drive1", 64'(p_configure), 64'(sl(0, 11'h205)));
      chk("t1_busy", 64'(busy), 64'd1);
      tick(); chk("t1_drive2", 64'(p_configure), 64'(sl(0, 11'h205)));
      tick(); chk("t1_drive3", 64'(p_configure), 64'(sl(0, 11'h205)));
      tick(); chk("t1_gap", 64'({p_configure, done}), 64'd0);
      tick(); chk("t1_done", 64'({done, busy, issued}), {58'd0, 1'b1, 1'b1, 4'd1});
      chk("t1_done_pcfg", 64'(p_configure), 64'd0);
      tick(); chk("t1_idle", 64'({done, busy}), 64'd0);

      // two entries, plus a start pulse while busy that must be ignored
      wr(0, 1, 11'h201, 2, 1'b0);
      wr(1, 3, 11'h201, 2, 1'b0);
      go(2);
      chk("t2_e0a", 64'(p_configure), 64'(sl(1, 11'h201)));
      start = 1'b1; prog_len = 4'd1;
      tick(); start = 1'b0;
      chk("t2_e0b", 64'(p_configure), 64'(sl(1, 11'h201)));
      tick(); chk("t2_gap0", 64'(p_configure), 64'd0);
      tick(); chk("t2_e1a", 64'(p_configure), 64'(sl(3, 11'h201)));
      chk("t2_iss1", 64'(issued), 64'd1);
      tick(); chk("t2_e1b", 64'(p_configure), 64'(sl(3, 11'h201)));
      tick(); chk("t2_gap1", 64'({p_configure, done}), 64'd0);
      tick(); chk("t2_done", 64'({done, issued}), {59'd0, 1'b1, 4'd2});
      tick();

      // wait for ready on processor 2; ready on processor 1 must not count
      wr(0, 2, 11'h7FF, 1, 1'b1);
      go(1);
      chk("t3_drive", 64'(p_configure), 64'(sl(2, 11'h7FF)));
      tick(); chk("t3_gap", 64'(p_configure), 64'd0);
      processor_ready_signals = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_waiting", 64'({busy, done, issued}), {58'd0, 1'b1, 1'b0, 4'd0});
      end
      processor_ready_signals = 4'b0100;
      tick(); chk("t3_done", 64'({done, busy, issued}), {58'd0, 1'b1, 1'b1, 4'd1});
      processor_ready_signals = '0;
      tick(); chk("t3_idle", 64'(busy), 64'd0);

      // hold 0 behaves as hold 1
      wr(0, 0, 11'h3FF, 0, 1'b0);
      go(1);
      chk("t4_drive", 64'(p_configure), 64'(sl(0, 11'h3FF)));
      tick(); chk("t4_gap", 64'(p_configure), 64'd0);
      tick(); chk("t4_done", 64'(done), 64'd1);
      tick();

      // zero length
      go(0);
      chk("t5_done", 64'({done, busy, issued, p_configure}), {15'd0, 1'b1, 1'b1, 4'd0, 44'd0});
      tick(); chk("t5_idle", 64'({done, busy}), 64'd0);

      // length above DEPTH is clamped
      for (int i = 0; i < DEPTH; i++) wr(i, i % NUM_PROC, CFG_W'(11'h100 + i), 1, 1'b0);
      go(15);
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      chk("t6_cycles", 64'(n), 64'd16);
      chk("t6_issued", 64'(issued), 64'd8);
      tick();

      // ready never arrives
      wr(0, 2, 11'h055, 1, 1'b1);
      processor_ready_signals = '0;
      go(1);
`ifdef NOC_CFG_TIMEOUT_EN
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      chk("t7_tmo_cycles", 64'(n), 64'd17);
      chk("t7_tmo_flag", 64'({timeout_err, issued}), {59'd0, 1'b1, 4'd1});
      tick();
      go(0);
      chk("t7_tmo_clear", 64'(timeout_err), 64'd0);
      tick();
`else
      n = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (done) n++;
      end
      chk("t7_no_done", 64'(n), 64'd0);
      chk("t7_still_busy", 64'({busy, timeout_err}), 64'd2);
      #2 reset = 1'b1;
      #1 chk("t7_rst_busy", 64'(busy), 64'd0);
      #3 reset = 1'b0;
      tick();
`endif

      // async reset during DRIVE; a write while busy must not land
      wr(0, 1, 11'h2AA, 4, 1'b0);
      go(1);
      tick(); chk("t8_drive", 64'(p_configure), 64'(sl(1, 11'h2AA)));
      prog_we = 1'b1; prog_addr = '0; prog_dest = 2'd3; prog_cfg = 11'h111;
      tick(); prog_we = 1'b0;
      #2 reset = 1'b1;
      #1 chk("t8_rst_async", 64'({p_configure, busy}), 64'd0);
      #3 reset = 1'b0;
      tick();
      go(1);
      chk("t8_table_kept", 64'(p_configure), 64'(sl(1, 11'h2AA)));
      n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      chk("t8_cycles", 64'(n), 64'd5);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
